// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache miss-fill engine.
package cache_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int MEM_LATENCY     = 4;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;
endpackage

// File: rtl/fill_counter.sv
// Word counter for a block fill: clear dominates enable; the extra MSB lets it reach WORDS_PER_BLOCK.
module fill_counter
  import cache_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [CNT_W_P-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W_P'(1);
  end
endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service engine: fetches one aligned block word by word from pipelined memory,
// streams each returned word into the data array and writes the tag with the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word_idx,
  output logic              write_tag_array
);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Block base is plain datapath: only meaningful while FILL, loaded by the opening miss.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && miss_detected) base_q <= miss_address & ~OFFSET_MASK;
  end

  // Both counters sit at zero throughout IDLE, so every fill starts from word 0.
  assign cnt_clr = (state_q == IDLE);

  fill_counter #(.CNT_W_P(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (mem_read),
    .cnt   (issue_cnt)
  );

  fill_counter #(.CNT_W_P(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (write_data_array),
    .cnt   (recv_cnt)
  );

  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_data        = '0;
    fill_word_idx    = '0;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) state_d = FILL;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_read         = mem_grant && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
        // Aligned base has zero offset bits, so OR-ing the word offset never carries.
        memory_address   = base_q | ADDR_W'({issue_cnt[CNT_W-2:0], 1'b0});
        write_data_array = memory_data_valid;
        fill_data        = memory_data;
        fill_word_idx    = recv_cnt[CNT_W-2:0];
        if (memory_data_valid && recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
          write_tag_array = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
